// File: rtl/shift_serializer_pkg.sv
// Shared types and constants for the shift_serializer parallel-in/serial-out engine.
package shift_serializer_pkg;

   localparam int DEFAULT_WIDTH = 8;

   // Direction encoding, captured alongside the data word.
   localparam logic DIR_LSB = 1'b0;
   localparam logic DIR_MSB = 1'b1;

   // PAR is only reachable when SHIFT_SERIALIZER_PARITY_EN is defined.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2
   } state_e;

endpackage

// File: rtl/shift_serializer_core.sv
// Shift register datapath: parallel load, one-step logical left/right shift,
// and selection of the bit currently presented at the output end.
module shift_serializer_core
   import shift_serializer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             shift_en_i,
   input  logic             dir_i,
   output logic             bit_o
);

   logic [WIDTH-1:0] shreg_q;
   logic [WIDTH-1:0] shreg_d;

   // Next shift-register value: load wins, otherwise shift toward the output end with zero fill.
   always_comb begin
      shreg_d = shreg_q;
      if (load_i) begin
         shreg_d = din_i;
      end else if (shift_en_i) begin
         if (dir_i == DIR_MSB) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
         end else begin
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
         end
      end else begin
         shreg_d = shreg_q;
      end
   end

   // Shift-register state, cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_q <= '0;
      end else begin
         shreg_q <= shreg_d;
      end
   end

   // Output end depends on the captured direction.
   always_comb begin
      if (dir_i == DIR_MSB) begin
         bit_o = shreg_q[WIDTH-1];
      end else begin
         bit_o = shreg_q[0];
      end
   end

endmodule

// File: rtl/shift_serializer.sv
// shift_serializer: one WIDTH-bit word in over valid/ready, serialized one bit
// per accepted beat, MSB- or LSB-first, with downstream backpressure.
// Optional feature macro: SHIFT_SERIALIZER_PARITY_EN appends an even-parity bit.
module shift_serializer
   import shift_serializer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] din,
   input  logic             msb_first,
   output logic             sout,
   output logic             sout_valid,
   input  logic             sout_ready,
   output logic             sout_last,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic             load_s;
   logic             shift_en_s;
   logic             last_data_s;
   logic             core_bit_s;
`ifdef SHIFT_SERIALIZER_PARITY_EN
   logic             par_q, par_d;
`endif

   assign load_s      = (state_q == IDLE) && in_valid;
   assign shift_en_s  = (state_q == SHIFT) && sout_ready;
   assign last_data_s = (cnt_q == CNT_W'(WIDTH - 1));

   shift_serializer_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (load_s),
      .din_i      (din),
      .shift_en_i (shift_en_s),
      .dir_i      (dir_q),
      .bit_o      (core_bit_s)
   );

   // State, bit counter and captured direction registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dir_q   <= DIR_LSB;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
      end
   end

   // Next-state, counter and direction capture; nothing moves while downstream stalls.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = SHIFT;
               cnt_d   = '0;
               dir_d   = msb_first;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            if (sout_ready) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (last_data_s) begin
`ifdef SHIFT_SERIALIZER_PARITY_EN
                  state_d = PAR;
`else
                  state_d = IDLE;
`endif
               end else begin
                  state_d = SHIFT;
               end
            end else begin
               state_d = SHIFT;
            end
         end
         PAR: begin
`ifdef SHIFT_SERIALIZER_PARITY_EN
            if (sout_ready) begin
               state_d = IDLE;
            end else begin
               state_d = PAR;
            end
`else
            state_d = IDLE;
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef SHIFT_SERIALIZER_PARITY_EN
   // Even parity of the word, taken at capture time.
   always_comb begin
      if (load_s) begin
         par_d = ^din;
      end else begin
         par_d = par_q;
      end
   end

   // Parity bit register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_q <= 1'b0;
      end else begin
         par_q <= par_d;
      end
   end
`endif

   // Outputs decoded only from registered state, so no ready/valid input reaches an output.
   always_comb begin
      in_ready   = (state_q == IDLE);
      busy       = (state_q != IDLE);
      sout       = 1'b0;
      sout_valid = 1'b0;
      sout_last  = 1'b0;
      case (state_q)
         IDLE: begin
            sout_valid = 1'b0;
         end
         SHIFT: begin
            sout       = core_bit_s;
            sout_valid = 1'b1;
`ifdef SHIFT_SERIALIZER_PARITY_EN
            sout_last  = 1'b0;
`else
            sout_last  = last_data_s;
`endif
         end
         PAR: begin
`ifdef SHIFT_SERIALIZER_PARITY_EN
            sout       = par_q;
            sout_valid = 1'b1;
            sout_last  = 1'b1;
`else
            sout_valid = 1'b0;
`endif
         end
         default: begin
            sout_valid = 1'b0;
         end
      endcase
   end

endmodule
